// File: rtl/bayer_quad_sort.sv
// bayer_quad_sort: reorders a 2x2 Bayer window into {R, G1, G2, B} and tags frame position.
// Define BAYER_GAVG_EN to add g_avg, a registered round-half-up average of G1 and G2.
module bayer_quad_sort #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_frame,
    input  logic [1:0]           pattern,
    input  logic [PIX_W-1:0]     wb_1,
    input  logic [PIX_W-1:0]     wb_2,
    input  logic [PIX_W-1:0]     wb_3,
    input  logic [PIX_W-1:0]     wb_4,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*PIX_W-1:0]   out,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef BAYER_GAVG_EN
    output logic [PIX_W-1:0]     g_avg,
`endif
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]        col_reg, col_next, col_cur;
    logic [RW-1:0]        row_reg, row_next, row_cur;
    logic [1:0]           pat_reg, pat_next, pat_cur;
    logic [4*PIX_W-1:0]   out_reg;
    logic                 out_valid_reg, sof_reg, eol_reg, eof_reg;
    logic                 in_xfer, rb, cb;
    logic [PIX_W-1:0]     win [4];
    logic [1:0]           sel [4];
    logic [4*PIX_W-1:0]   sorted_next;

    assign in_ready = !out_valid_reg || out_ready;
    assign in_xfer  = in_valid && in_ready;

    // A start_frame pulse takes effect on the window accepted in the same cycle.
    assign col_cur = start_frame ? '0 : col_reg;
    assign row_cur = start_frame ? '0 : row_reg;
    assign pat_cur = start_frame ? pattern : pat_reg;
    assign rb      = ~(row_cur[0] ^ pat_cur[1]);
    assign cb      = col_cur[0] ^ pat_cur[0];

    assign win[0] = wb_1;
    assign win[1] = wb_2;
    assign win[2] = wb_3;
    assign win[3] = wb_4;

    // sel[lane] picks the window sample for lanes R, G1, G2, B.
    always_comb begin
        sel[0] = 2'd0; sel[1] = 2'd1; sel[2] = 2'd2; sel[3] = 2'd3;
        case ({rb, cb})
            2'b11: begin sel[0] = 2'd1; sel[1] = 2'd0; sel[2] = 2'd3; sel[3] = 2'd2; end
            2'b00: begin sel[0] = 2'd2; sel[1] = 2'd0; sel[2] = 2'd3; sel[3] = 2'd1; end
            2'b01: begin sel[0] = 2'd3; sel[1] = 2'd1; sel[2] = 2'd2; sel[3] = 2'd0; end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign sorted_next[(3-gi)*PIX_W +: PIX_W] = win[sel[gi]];
        end
    endgenerate

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        pat_next = pat_reg;
        if (start_frame) begin
            col_next = '0;
            row_next = '0;
            pat_next = pattern;
        end
        if (in_xfer) begin
            if (col_cur == COL_LAST) begin
                col_next = '0;
                row_next = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
            end else begin
                col_next = col_cur + CW'(1);
                row_next = row_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_reg       <= '0;
            row_reg       <= '0;
            pat_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            sof_reg       <= 1'b0;
            eol_reg       <= 1'b0;
            eof_reg       <= 1'b0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
            pat_reg <= pat_next;
            if (in_xfer) begin
                out_reg       <= sorted_next;
                out_valid_reg <= 1'b1;
                sof_reg       <= (col_cur == '0) && (row_cur == '0);
                eol_reg       <= (col_cur == COL_LAST);
                eof_reg       <= (col_cur == COL_LAST) && (row_cur == ROW_LAST);
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef BAYER_GAVG_EN
    logic [PIX_W:0]   g_sum_next;
    logic [PIX_W-1:0] g_avg_reg;

    assign g_sum_next = {1'b0, win[sel[1]]} + {1'b0, win[sel[2]]} + (PIX_W+1)'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            g_avg_reg <= '0;
        else if (in_xfer)
            g_avg_reg <= g_sum_next[PIX_W:1];
    end

    assign g_avg = g_avg_reg;
`endif

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_sof   = sof_reg;
    assign out_eol   = eol_reg;
    assign out_eof   = eof_reg;
endmodule

// File: tb/tb_bayer_quad_sort.sv
// Directed bench for bayer_quad_sort: a 2x2-window frame (dut_a) and an 8x4 frame (dut_b) share stimulus.
module tb_bayer_quad_sort;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic start_frame = 1'b0;
    logic [1:0] pattern = 2'd0;
    logic [PW-1:0] wb_1 = '0, wb_2 = '0, wb_3 = '0, wb_4 = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;

    logic in_ready_a, out_valid_a, sof_a, eol_a, eof_a;
    logic in_ready_b, out_valid_b, sof_b, eol_b, eof_b;
    logic [4*PW-1:0] out_a, out_b;
`ifdef BAYER_GAVG_EN
    logic [PW-1:0] g_avg_a, g_avg_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bayer_quad_sort #(.PIX_W(PW), .IMG_W(2), .IMG_H(2)) dut_a (
        .clk(clk), .n_rst(n_rst), .start_frame(start_frame), .pattern(pattern),
        .wb_1(wb_1), .wb_2(wb_2), .wb_3(wb_3), .wb_4(wb_4),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .out(out_a), .out_valid(out_valid_a), .out_ready(out_ready),
`ifdef BAYER_GAVG_EN
        .g_avg(g_avg_a),
`endif
        .out_sof(sof_a), .out_eol(eol_a), .out_eof(eof_a)
    );

    bayer_quad_sort #(.PIX_W(PW), .IMG_W(8), .IMG_H(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .start_frame(start_frame), .pattern(pattern),
        .wb_1(wb_1), .wb_2(wb_2), .wb_3(wb_3), .wb_4(wb_4),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .out(out_b), .out_valid(out_valid_b), .out_ready(out_ready),
`ifdef BAYER_GAVG_EN
        .g_avg(g_avg_b),
`endif
        .out_sof(sof_b), .out_eol(eol_b), .out_eof(eof_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One accepted window; assumes in_ready is high. Returns #1 after the capturing edge.
    task automatic send(input logic [7:0] a, b, c, d, input logic sf, input logic [1:0] p);
        wb_1 = a; wb_2 = b; wb_3 = c; wb_4 = d;
        start_frame = sf; pattern = p; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; start_frame = 1'b0;
        $display("window %0d,%0d,%0d,%0d sf=%0d pat=%0d -> a=0x%08h b=0x%08h sof=%0d eol=%0d eof=%0d",
                 a, b, c, d, sf, p, out_a, out_b, sof_a, eol_a, eof_a);
    endtask

    logic [7:0]  in_tab  [4][4];
    logic [31:0] exp_tab [4];
    logic [31:0] held;
    bit stalled_prev;
    int k, got_n, cyc;

    initial begin
        in_tab[0] = '{8'h10, 8'h11, 8'h12, 8'h13};
        in_tab[1] = '{8'h20, 8'h21, 8'h22, 8'h23};
        in_tab[2] = '{8'h30, 8'h31, 8'h32, 8'h33};
        in_tab[3] = '{8'h40, 8'h41, 8'h42, 8'h43};
        exp_tab   = '{32'h10111213, 32'h21202322, 32'h32303331, 32'h43414240};

        // Reset state
        #1;
        check("rst_out", out_a, 32'h0);
        check("rst_valid", out_valid_a, 0);
        check("rst_flags", {sof_a, eol_a, eof_a}, 0);
        check("rst_in_ready", in_ready_a, 1);
        @(posedge clk); @(posedge clk); #3;
        n_rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready_a, 1);

        // start_frame alone leaves the output untouched
        start_frame = 1'b1; pattern = 2'd0;
        @(posedge clk); #1;
        start_frame = 1'b0;
        check("sf_alone_valid", out_valid_a, 0);

        send(11, 22, 33, 44, 1'b0, 2'd0);
        check("w0_out", out_a, 32'h0B16212C);
        check("w0_valid", out_valid_a, 1);
        check("w0_flags", {sof_a, eol_a, eof_a}, 3'b100);

        send(11, 22, 33, 44, 1'b0, 2'd0);
        check("w1_out", out_a, 32'h160B2C21);
        check("w1_flags", {sof_a, eol_a, eof_a}, 3'b010);

        send(1, 2, 3, 4, 1'b0, 2'd0);
        check("w2_out", out_a, 32'h03010402);
        check("w2_flags", {sof_a, eol_a, eof_a}, 3'b000);

        send(1, 2, 3, 4, 1'b0, 2'd0);
        check("w3_out", out_a, 32'h04020301);
        check("w3_flags", {sof_a, eol_a, eof_a}, 3'b011);

        send(1, 2, 3, 4, 1'b0, 2'd0);
        check("w4_out", out_a, 32'h01020304);
        check("w4_flags", {sof_a, eol_a, eof_a}, 3'b100);
        check("b_w4_flags", {sof_b, eol_b, eof_b}, 3'b000);

        // dut_b sits at col 5; restart with pattern 3 on the same cycle
        send(1, 2, 3, 4, 1'b1, 2'd3);
        check("b_sf_mid_out", out_b, 32'h04020301);
        check("b_sf_mid_sof", sof_b, 1);
        check("a_sf_mid_out", out_a, 32'h04020301);

        send(5, 6, 7, 8, 1'b0, 2'd0);
        check("b_after_sf_out", out_b, 32'h07050806);
        check("b_after_sf_sof", sof_b, 0);
        check("a_after_sf_out", out_a, 32'h07050806);

        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_valid", out_valid_a, 0);

        // Five-cycle output stall under continuous input
        start_frame = 1'b1; pattern = 2'd0;
        @(posedge clk); #1;
        start_frame = 1'b0;
        k = 0; got_n = 0; cyc = 0; stalled_prev = 0; held = '0;
        while (got_n < 4 && cyc < 40) begin
            in_valid = (k < 4);
            if (k < 4) begin
                wb_1 = in_tab[k][0]; wb_2 = in_tab[k][1];
                wb_3 = in_tab[k][2]; wb_4 = in_tab[k][3];
            end
            out_ready = (cyc >= 1 && cyc <= 5) ? 1'b0 : 1'b1;
            #3;
            if (out_valid_a && !out_ready) begin
                check("stall_in_ready", in_ready_a, 0);
                if (stalled_prev) check("stall_hold", out_a, held);
                held = out_a;
                stalled_prev = 1;
            end else begin
                stalled_prev = 0;
            end
            if (out_valid_a && out_ready) begin
                check("stream_order", out_a, exp_tab[got_n]);
                $display("stream out %0d: 0x%08h", got_n, out_a);
                got_n++;
            end
            if (in_valid && in_ready_a) k++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got_n, 4);

        // Reset during an output stall
        send(1, 10, 13, 4, 1'b1, 2'd3);
        check("gavg_out", out_a, 32'h040A0D01);
`ifdef BAYER_GAVG_EN
        check("gavg_value", g_avg_a, 12);
`endif
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("stall_valid", out_valid_a, 1);
        check("stall_out", out_a, 32'h040A0D01);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_valid", out_valid_a, 0);
        check("async_rst_out", out_a, 32'h0);
        check("async_rst_in_ready", in_ready_a, 1);
`ifdef BAYER_GAVG_EN
        check("async_rst_gavg", g_avg_a, 0);
`endif
        @(posedge clk); #3;
        n_rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rerst_valid", out_valid_a, 0);
        check("rerst_in_ready", in_ready_a, 1);

        // Pattern register was cleared by reset; input pattern 3 is ignored without start_frame
        send(1, 2, 3, 4, 1'b0, 2'd3);
        check("after_rst_out", out_a, 32'h01020304);
        check("after_rst_sof", sof_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bayer_quad_sort.md
BAYER_QUAD_SORT -- requirements
Module: bayer_quad_sort

Interface
REQ-001 Parameter PIX_W, default 8, is the bit width of one pixel sample.
REQ-002 Parameter IMG_W, default 640, is the number of 2x2 windows per row; legal range is 2 or more.
REQ-003 Parameter IMG_H, default 480, is the number of window rows per frame; legal range is 2 or more.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start_frame, input, 1 bit: single-cycle pulse that restarts position tracking.
REQ-007 Port pattern, input, 2 bits: Bayer phase of the frame. 0 = RGGB, 1 = GRBG, 2 = GBRG, 3 = BGGR.
REQ-008 Ports wb_1, wb_2, wb_3, wb_4, input, PIX_W bits each: window samples in order top-left, top-right, bottom-left, bottom-right.
REQ-009 Port in_valid, input, 1 bit, and port in_ready, output, 1 bit: input handshake.
REQ-010 Port out, output, 4*PIX_W bits: {R, G1, G2, B}, with R in the MSBs.
REQ-011 Port out_valid, output, 1 bit, and port out_ready, input, 1 bit: output handshake.
REQ-012 Ports out_sof, out_eol and out_eof, output, 1 bit each: flags qualified by out_valid.

Function
REQ-013 An input transfer shall occur when in_valid and in_ready are both 1 on a clock edge; an output transfer shall occur when out_valid and out_ready are both 1.
REQ-014 in_ready shall equal (!out_valid || out_ready), combinationally; this gives a 1-entry pipeline register with no bubble under continuous flow.
REQ-015 Latency from an input transfer to out_valid shall be exactly 1 cycle.
REQ-016 out and the out flags shall stay stable while out_valid=1 and out_ready=0.
REQ-017 out_valid shall be set on an input transfer, and shall clear on an output transfer that has no simultaneous input transfer.
REQ-018 The block shall keep a column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1), both $clog2-sized, plus a pattern register pat.
REQ-019 Each input transfer shall advance col by 1; at IMG_W-1, col shall wrap to 0 and row shall advance by 1; at IMG_H-1, row shall wrap to 0.
REQ-020 The phase bits shall be rb = ~(row[0] ^ pat[1]) and cb = col[0] ^ pat[0], computed from the position of the window being accepted.
REQ-021 Mapping for rb=1, cb=0: R=wb_1, G1=wb_2, G2=wb_3, B=wb_4.
REQ-022 Mapping for rb=1, cb=1: G1=wb_1, R=wb_2, B=wb_3, G2=wb_4.
REQ-023 Mapping for rb=0, cb=0: G1=wb_1, B=wb_2, R=wb_3, G2=wb_4.
REQ-024 Mapping for rb=0, cb=1: B=wb_1, G1=wb_2, G2=wb_3, R=wb_4.
REQ-025 Flags for the captured window: out_sof=1 at (row 0, col 0); out_eol=1 at col IMG_W-1; out_eof=1 at (row IMG_H-1, col IMG_W-1).
REQ-026 start_frame=1 shall set col=0 and row=0 and load pat from pattern; this is legal mid-frame and discards the old position.
REQ-027 If start_frame and an input transfer occur in the same cycle, that window shall be processed as position (0,0) using the new pattern, and the counters shall then advance to col=1.
REQ-028 When there is no input transfer, the counters shall hold; start_frame shall not alter out, out_valid or the flags.
REQ-029 The block shall drop and duplicate no window under any in_valid/out_ready pattern.

Reset
REQ-030 While n_rst=0, the block shall immediately force out=0, out_valid=0, out_sof=0, out_eol=0, out_eof=0, col=0, row=0 and pat=0, independent of clk.
REQ-031 in_ready shall be 1 during reset and on the first cycle after reset.
REQ-032 A reset asserted mid-frame or mid-stall shall discard any held output without a transfer.

Configuration
REQ-033 When the macro BAYER_GAVG_EN is defined, the block shall add output port g_avg (PIX_W bits), registered with out, equal to (G1+G2+1)>>1 computed at PIX_W+1 bits (round half up), and reset to 0.
REQ-034 When BAYER_GAVG_EN is undefined, port g_avg and its logic shall not exist, and all other behaviour shall be identical.

Verification
REQ-035 Scenario: PIX_W=8, reset, start_frame with pattern=0, one window 11,22,33,44 at (0,0) -> next cycle out=0x0B16212C, out_valid=1, out_sof=1.
REQ-036 Scenario: pattern=0, second window 11,22,33,44 at col 1 -> out={22,11,44,33}=0x160B2C21; with IMG_W=2, out_eol=1.
REQ-037 Scenario: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out frozen; after release, every window appears exactly once and in order.
REQ-038 Scenario: IMG_W=2, IMG_H=2, four windows -> out_eof=1 on the 4th only; the 5th window gets out_sof=1.
REQ-039 Scenario: start_frame with pattern=3 in the same cycle as an accepted window 1,2,3,4 at mid-frame col 5 -> out={4,2,3,1}, out_sof=1.
REQ-040 Scenario: n_rst pulled low during an output stall -> out_valid=0 and out=0 immediately; with BAYER_GAVG_EN, G1=10 and G2=13 give g_avg=12.
